seq_serializer: RTL

Parallel-to-serial front end for the sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and streams it one bit per enabled clock onto a serial line. That line drives the detector's serial data input directly. A per-bit valid flag, a busy flag and an end-of-word pulse let the surrounding logic align detector output with word boundaries.

---
 rtl/seq_serializer.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the sequence detector.
// Streams a WIDTH-bit word one bit per shift_en onto dout.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             dout_n, dv_n, busy_n, done_n;
  logic             last, accept;

  assign last       = (state == SHIFT) && shift_en && (cnt == LAST);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    dout_n  = dout;
    dv_n    = dout_valid;
    done_n  = 1'b0;
    if (accept) begin
      // Also covers the back-to-back handoff on the last-bit edge.
      state_n = SHIFT;
      sreg_n  = load_data;
      cnt_n   = '0;
      dv_n    = 1'b1;
      dout_n  = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
      done_n  = last;
    end else begin
      unique case (state)
        IDLE: begin
          dout_n = 1'b0;
          dv_n   = 1'b0;
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
              state_n = IDLE;
              cnt_n   = '0;
              dout_n  = 1'b0;
              dv_n    = 1'b0;
              done_n  = 1'b1;
            end else begin
              sreg_n = LSB_FIRST ? (sreg >> 1) : (sreg << 1);
              cnt_n  = cnt + 1'b1;
              dout_n = LSB_FIRST ? sreg[1] : sreg[WIDTH-2];
            end
          end
        end
      endcase
    end
    busy_n = (state_n == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sreg       <= sreg_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule
